// File: rtl/cardjitsu_turn_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cardjitsu_turn_sched                                       |
// | Description : Two-player turn scheduler for the Card-Jitsu game core.    |
// |               Synchronises the raw player buttons, alternates P1 and P2  |
// |               card selections, offers each selection to the game core    |
// |               over a valid/ready handshake, tracks which deck slots each |
// |               player has consumed and sequences rounds until the deck is |
// |               exhausted or the core declares a winner.                   |
// | Config      : define CJ_TURN_TIMEOUT_EN to enable the selection timeout  |
// |               (auto-play of the lowest unused slot after TIMEOUT_CYC     |
// |               cycles in a selection phase). Default build: no timeout,   |
// |               timeout_evt tied low.                                      |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               start            - begin-match pulse (IDLE / DONE only)    |
// |               p1_btn, p2_btn   - raw asynchronous player buttons         |
// |               p1_slot, p2_slot - requested deck slot (0..5 legal)        |
// |               core_valid/core_player/core_slot/core_ready - selection    |
// |               handshake towards the game core                            |
// |               round_done, game_over - round / match status from core     |
// |               turn             - one-hot active player ([0]=P1,[1]=P2)   |
// |               used1, used2     - consumed-slot masks                     |
// |               timeout_evt      - one-cycle auto-play pulse               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cardjitsu_turn_sched #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       p1_btn,
    input  logic       p2_btn,
    input  logic [2:0] p1_slot,
    input  logic [2:0] p2_slot,
    output logic       core_valid,
    output logic       core_player,
    output logic [2:0] core_slot,
    input  logic       core_ready,
    input  logic       round_done,
    input  logic       game_over,
    output logic [1:0] turn,
    output logic [5:0] used1,
    output logic [5:0] used2,
    output logic       timeout_evt
);

    localparam logic [2:0] c_NUM_SLOTS = 3'd6;
    localparam logic [5:0] c_ALL_USED  = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_P1_SEL     = 3'd1,
        S_P1_ISSUE   = 3'd2,
        S_P2_SEL     = 3'd3,
        S_P2_ISSUE   = 3'd4,
        S_WAIT_ROUND = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t     r_state;
    logic       r_core_valid;
    logic       r_core_player;
    logic [2:0] r_core_slot;
    logic [5:0] r_used1;
    logic [5:0] r_used2;

    // ------------------------------------------------------------------
    // Button synchronisers: meta -> sync, plus a previous-value flop for
    // rising-edge detection. All reset to 0, so a button held across
    // reset release is seen as a fresh press.
    // ------------------------------------------------------------------
    logic r_p1_meta, r_p1_sync, r_p1_prev;
    logic r_p2_meta, r_p2_sync, r_p2_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_meta <= 1'b0;
            r_p1_sync <= 1'b0;
            r_p1_prev <= 1'b0;
            r_p2_meta <= 1'b0;
            r_p2_sync <= 1'b0;
            r_p2_prev <= 1'b0;
        end else begin
            r_p1_meta <= p1_btn;
            r_p1_sync <= r_p1_meta;
            r_p1_prev <= r_p1_sync;
            r_p2_meta <= p2_btn;
            r_p2_sync <= r_p2_meta;
            r_p2_prev <= r_p2_sync;
        end
    end

    logic       w_p1_press;
    logic       w_p2_press;
    logic [5:0] w_p1_mask;
    logic [5:0] w_p2_mask;
    logic       w_p1_ok;
    logic       w_p2_ok;
    logic [5:0] w_issue_mask;

    assign w_p1_press = r_p1_sync & ~r_p1_prev;
    assign w_p2_press = r_p2_sync & ~r_p2_prev;

    // Slots 6/7 shift the one-hot mask out of range; the explicit range
    // test below rejects them regardless.
    assign w_p1_mask    = 6'b000001 << p1_slot;
    assign w_p2_mask    = 6'b000001 << p2_slot;
    assign w_p1_ok      = (p1_slot < c_NUM_SLOTS) && ((r_used1 & w_p1_mask) == 6'd0);
    assign w_p2_ok      = (p2_slot < c_NUM_SLOTS) && ((r_used2 & w_p2_mask) == 6'd0);
    assign w_issue_mask = 6'b000001 << r_core_slot;

`ifdef CJ_TURN_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Selection timeout: counter is zero on the first cycle of a selection
    // phase and counts every cycle spent there.
    // ------------------------------------------------------------------
    localparam int unsigned       c_CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_sel_cnt;
    logic               r_timeout_evt;
    logic               w_in_sel;
    logic               w_timeout;
    logic [5:0]         w_sel_used;
    logic [2:0]         w_low_free;

    assign w_in_sel   = (r_state == S_P1_SEL) || (r_state == S_P2_SEL);
    assign w_timeout  = (r_sel_cnt == c_TO_LAST);
    assign w_sel_used = (r_state == S_P2_SEL) ? r_used2 : r_used1;

    // Descending scan so the lowest free slot is the last one written.
    always_comb begin
        w_low_free = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (!w_sel_used[i]) begin
                w_low_free = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_cnt <= '0;
        end else if (w_in_sel) begin
            r_sel_cnt <= r_sel_cnt + 1'b1;
        end else begin
            r_sel_cnt <= '0;
        end
    end

    assign timeout_evt = r_timeout_evt;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_evt          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Turn sequencing FSM with registered handshake outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_core_valid  <= 1'b0;
            r_core_player <= 1'b0;
            r_core_slot   <= 3'd0;
            r_used1       <= 6'd0;
            r_used2       <= 6'd0;
`ifdef CJ_TURN_TIMEOUT_EN
            r_timeout_evt <= 1'b0;
`endif
        end else begin
`ifdef CJ_TURN_TIMEOUT_EN
            r_timeout_evt <= 1'b0;
`endif
            // A winner ends the match from anywhere but IDLE, dropping any
            // offer the core has not yet taken.
            if (game_over && (r_state != S_IDLE)) begin
                r_state      <= S_DONE;
                r_core_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_used1 <= 6'd0;
                            r_used2 <= 6'd0;
                            r_state <= S_P1_SEL;
                        end
                    end

                    S_P1_SEL: begin
                        if (w_p1_press && w_p1_ok) begin
                            r_core_player <= 1'b0;
                            r_core_slot   <= p1_slot;
                            r_core_valid  <= 1'b1;
                            r_state       <= S_P1_ISSUE;
                        end
`ifdef CJ_TURN_TIMEOUT_EN
                        else if (w_timeout) begin
                            r_core_player <= 1'b0;
                            r_core_slot   <= w_low_free;
                            r_core_valid  <= 1'b1;
                            r_timeout_evt <= 1'b1;
                            r_state       <= S_P1_ISSUE;
                        end
`endif
                    end

                    S_P1_ISSUE: begin
                        if (r_core_valid && core_ready) begin
                            r_used1      <= r_used1 | w_issue_mask;
                            r_core_valid <= 1'b0;
                            r_state      <= S_P2_SEL;
                        end
                    end

                    S_P2_SEL: begin
                        if (w_p2_press && w_p2_ok) begin
                            r_core_player <= 1'b1;
                            r_core_slot   <= p2_slot;
                            r_core_valid  <= 1'b1;
                            r_state       <= S_P2_ISSUE;
                        end
`ifdef CJ_TURN_TIMEOUT_EN
                        else if (w_timeout) begin
                            r_core_player <= 1'b1;
                            r_core_slot   <= w_low_free;
                            r_core_valid  <= 1'b1;
                            r_timeout_evt <= 1'b1;
                            r_state       <= S_P2_ISSUE;
                        end
`endif
                    end

                    S_P2_ISSUE: begin
                        if (r_core_valid && core_ready) begin
                            r_used2      <= r_used2 | w_issue_mask;
                            r_core_valid <= 1'b0;
                            r_state      <= S_WAIT_ROUND;
                        end
                    end

                    S_WAIT_ROUND: begin
                        if (round_done) begin
                            if ((r_used1 != c_ALL_USED) && (r_used2 != c_ALL_USED)) begin
                                r_state <= S_P1_SEL;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end
                    end

                    default: begin
                        r_state      <= S_IDLE;
                        r_core_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign core_valid  = r_core_valid;
    assign core_player = r_core_player;
    assign core_slot   = r_core_slot;
    assign used1       = r_used1;
    assign used2       = r_used2;
    assign turn        = ((r_state == S_P1_SEL) || (r_state == S_P1_ISSUE)) ? 2'b01 :
                         ((r_state == S_P2_SEL) || (r_state == S_P2_ISSUE)) ? 2'b10 :
                                                                              2'b00;

endmodule
`default_nettype wire

// File: tb/tb_cardjitsu_turn_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cardjitsu_turn_sched                                    |
// | Description : Self-checking bench for cardjitsu_turn_sched. A game-level |
// |               reference model (press history, whose turn, pending offer, |
// |               slot masks) predicts every output after every clock edge.  |
// |               Directed scenarios are followed by randomized play.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cardjitsu_turn_sched;

    localparam int unsigned c_TIMEOUT = 8;
`ifdef CJ_TURN_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       p1_btn, p2_btn;
    logic [2:0] p1_slot, p2_slot;
    logic       core_valid, core_player;
    logic [2:0] core_slot;
    logic       core_ready, round_done, game_over;
    logic [1:0] turn;
    logic [5:0] used1, used2;
    logic       timeout_evt;

    int n_checks = 0;
    int n_errors = 0;

    cardjitsu_turn_sched #(.TIMEOUT_CYC(c_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .p1_btn      (p1_btn),
        .p2_btn      (p2_btn),
        .p1_slot     (p1_slot),
        .p2_slot     (p2_slot),
        .core_valid  (core_valid),
        .core_player (core_player),
        .core_slot   (core_slot),
        .core_ready  (core_ready),
        .round_done  (round_done),
        .game_over   (game_over),
        .turn        (turn),
        .used1       (used1),
        .used2       (used2),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_turn_of;      // 0 nobody, 1 P1, 2 P2
    bit         m_offer;        // selection waiting for the core
    bit         m_await;        // both played, waiting for round result
    bit         m_over;         // match finished
    bit         m_idle;         // never started since reset
    bit         m_evt;
    logic       m_player;
    logic [2:0] m_slot;
    logic [5:0] m_used1, m_used2;
    logic [2:0] m_h1, m_h2;     // button samples at the last three edges, [0] newest
    int         m_sel_cnt;      // cycles spent in the current selection phase

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] lowest_free(input logic [5:0] u);
        for (int i = 0; i < 6; i++) begin
            if (!u[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic logic [1:0] exp_turn();
        if (m_turn_of == 1) return 2'b01;
        if (m_turn_of == 2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_turn_of = 0; m_offer = 0; m_await = 0; m_over = 0; m_idle = 1; m_evt = 0;
        m_player = 1'b0; m_slot = 3'd0; m_used1 = 6'd0; m_used2 = 6'd0;
        m_h1 = 3'd0; m_h2 = 3'd0; m_sel_cnt = 0;
    endtask

    // Advance the model by one rising edge using the inputs present now.
    task automatic model_edge();
        logic       p1p, p2p, pp;
        logic [2:0] s;
        logic [5:0] u;
        p1p   = m_h1[1] & ~m_h1[2];
        p2p   = m_h2[1] & ~m_h2[2];
        m_evt = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (game_over && !m_idle) begin
            m_over = 1; m_offer = 0; m_await = 0; m_turn_of = 0;
        end else if (m_idle || m_over) begin
            if (start) begin
                m_used1 = 6'd0; m_used2 = 6'd0;
                m_idle = 0; m_over = 0; m_turn_of = 1; m_offer = 0;
            end
        end else if (m_offer) begin
            if (core_ready) begin
                m_offer = 0;
                if (m_turn_of == 1) begin
                    m_used1   = m_used1 | (6'b000001 << m_slot);
                    m_turn_of = 2;
                end else begin
                    m_used2   = m_used2 | (6'b000001 << m_slot);
                    m_turn_of = 0;
                    m_await   = 1;
                end
            end
        end else if (m_turn_of != 0) begin
            pp = (m_turn_of == 1) ? p1p : p2p;
            s  = (m_turn_of == 1) ? p1_slot : p2_slot;
            u  = (m_turn_of == 1) ? m_used1 : m_used2;
            if (pp && (s < 3'd6) && !u[s]) begin
                m_offer = 1; m_slot = s; m_player = (m_turn_of == 2);
            end else if (c_TO_EN && (m_sel_cnt == int'(c_TIMEOUT) - 1)) begin
                m_offer = 1; m_slot = lowest_free(u); m_player = (m_turn_of == 2); m_evt = 1;
            end
            m_sel_cnt++;
        end else if (m_await) begin
            if (round_done) begin
                m_await = 0;
                if ((m_used1 != 6'h3f) && (m_used2 != 6'h3f)) m_turn_of = 1;
                else m_over = 1;
            end
        end
        if ((m_turn_of == 0) || m_offer) m_sel_cnt = 0;
        m_h1 = {m_h1[1:0], p1_btn};
        m_h2 = {m_h2[1:0], p2_btn};
    endtask

    task automatic compare();
        chk("core_valid", core_valid, m_offer);
        chk("turn", turn, exp_turn());
        chk("used1", used1, m_used1);
        chk("used2", used2, m_used2);
        chk("timeout_evt", timeout_evt, m_evt);
        if (m_offer || !rst_n) begin
            chk("core_player", core_player, m_player);
            chk("core_slot", core_slot, m_slot);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic press(input int who, input logic [2:0] slot);
        if (who == 1) begin p1_slot = slot; p1_btn = 1'b1; end
        else          begin p2_slot = slot; p2_btn = 1'b1; end
        step(); step();
        p1_btn = 1'b0; p2_btn = 1'b0;
        step(); step();
    endtask

    task automatic handshake(input int wait_cyc);
        core_ready = 1'b0;
        repeat (wait_cyc) step();
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
    endtask

    task automatic pulse_round_done();
        round_done = 1'b1; step(); round_done = 1'b0;
    endtask

    task automatic restart();
        game_over = 1'b1; step(); game_over = 1'b0;
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [2:0] to_slot;

        rst_n = 1'b0; start = 1'b0; p1_btn = 1'b0; p2_btn = 1'b0;
        p1_slot = 3'd0; p2_slot = 3'd0; core_ready = 1'b0; round_done = 1'b0; game_over = 1'b0;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_valid", core_valid, 0);
        chk("rst_turn", turn, 0);
        chk("rst_used1", used1, 0);
        chk("rst_slot", core_slot, 0);
        rst_n = 1'b1;
        step();

        // Press-to-valid latency and held offer
        start = 1'b1; step(); start = 1'b0;
        p1_slot = 3'd2; p1_btn = 1'b1;
        step(); chk("lat_edge1", core_valid, 0);
        step(); chk("lat_edge2", core_valid, 0);
        p1_btn = 1'b0;
        step(); chk("lat_edge3", core_valid, 1);
        chk("lat_slot", core_slot, 2);
        chk("lat_player", core_player, 0);
        repeat (4) step();
        chk("hold_slot", core_slot, 2);
        core_ready = 1'b1; step(); core_ready = 1'b0;
        chk("hs_used1", used1, 6'b000100);
        chk("hs_turn", turn, 2'b10);
        chk("hs_valid_drop", core_valid, 0);

        // Illegal and already-used P2 slots are ignored
        press(2, 3'd0); handshake(1); pulse_round_done();
        press(1, 3'd3); handshake(0);
        press(2, 3'd7);
        press(2, 3'd0);
`ifndef CJ_TURN_TIMEOUT_EN
        chk("ignored_presses", core_valid, 0);
`endif
        press(2, 3'd5);
`ifndef CJ_TURN_TIMEOUT_EN
        chk("p2_slot5", core_slot, 5);
        chk("p2_player", core_player, 1);
`endif
        handshake(0); pulse_round_done();

        // Six full rounds exhaust the deck
        restart();
        for (int r = 0; r < 6; r++) begin
            press(1, 3'(r)); handshake(r % 3);
            press(2, 3'(5 - r)); handshake(0);
            pulse_round_done();
        end
        chk("done_turn", turn, 0);
        chk("done_used1", used1, 6'h3f);
        chk("done_used2", used2, 6'h3f);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_used1", used1, 0);
        chk("restart_turn", turn, 2'b01);

        // game_over abandons a pending offer
        press(1, 3'd4);
        game_over = 1'b1; step(); game_over = 1'b0;
        chk("go_valid", core_valid, 0);
        chk("go_used1", used1, 0);
        chk("go_turn", turn, 0);

`ifdef CJ_TURN_TIMEOUT_EN
        // Auto-play after timeout, and press coincident with timeout
        restart();
        press(1, 3'd0); handshake(0); press(2, 3'd0); handshake(0); pulse_round_done();
        press(1, 3'd1); handshake(0); press(2, 3'd1); handshake(0); pulse_round_done();
        pulses = 0; to_slot = 3'd0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (timeout_evt) begin pulses++; to_slot = core_slot; end
        end
        chk("to_pulses", pulses, 1);
        chk("to_slot", to_slot, 2);
        handshake(0); press(2, 3'd2); handshake(0); pulse_round_done();
        repeat (5) step();
        p1_slot = 3'd4; p1_btn = 1'b1;
        step(); step();
        p1_btn = 1'b0;
        step();
        chk("coinc_evt", timeout_evt, 0);
        chk("coinc_valid", core_valid, 1);
        chk("coinc_slot", core_slot, 4);
        handshake(0);
`endif

        // Asynchronous reset during P2 offer
        restart();
        press(1, 3'd1); handshake(0);
        press(2, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", core_valid, 0);
        chk("arst_turn", turn, 0);
        chk("arst_used1", used1, 0);
        chk("arst_slot", core_slot, 0);
        chk("arst_player", core_player, 0);
        chk("arst_evt", timeout_evt, 0);
        model_reset();
        step(); step();
        p1_btn = 1'b1;
        rst_n = 1'b1;
        repeat (6) step();
        chk("post_rst_idle", core_valid, 0);
        p1_btn = 1'b0;
        step();

        // Randomized play
        restart();
        for (int c = 0; c < 4000; c++) begin
            start      = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 2) == 0) p1_btn = ~p1_btn;
            if ($urandom_range(0, 2) == 0) p2_btn = ~p2_btn;
            p1_slot    = 3'($urandom_range(0, 7));
            p2_slot    = 3'($urandom_range(0, 7));
            core_ready = 1'($urandom_range(0, 1));
            round_done = ($urandom_range(0, 3) == 0);
            game_over  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step(); step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
